// File: rtl/speech_pkg.sv
// Shared types and constants for the phoneme playback path.
// The default phoneme address table also lives here so the ROM and any
// other user agree on one set of contents.
package speech_pkg;

    localparam int CODE_W = 6;
    localparam int ADDR_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_LOAD   = 3'd2,
        ST_PLAY   = 3'd3,
        ST_GAP    = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] start;
        logic [ADDR_W-1:0] finish;
    } phoneme_addr_t;

    // Phoneme address table (mirrors phoneme_addr.hex). Each phoneme owns a
    // 64 KiB flash window and uses its first 4 KiB; code 5 sits low in flash
    // and code 2 is a deliberately corrupt entry (finish below start).
    function automatic phoneme_addr_t default_entry(input logic [CODE_W-1:0] code);
        phoneme_addr_t e;
        case (code)
            6'd2: begin
                e.start  = 24'h000800;
                e.finish = 24'h0007FF;
            end
            6'd5: begin
                e.start  = 24'h001000;
                e.finish = 24'h001FFF;
            end
            default: begin
                e.start  = {{(ADDR_W-CODE_W-16){1'b0}}, code, 16'h0000};
                e.finish = {{(ADDR_W-CODE_W-16){1'b0}}, code, 16'h0FFF};
            end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/phoneme_addr_rom.sv
// Registered code -> {start, finish} flash address ROM.
// One clock of latency: the entry for code_i appears on entry_o after the
// next rising clock edge.
module phoneme_addr_rom
    import speech_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [CODE_W-1:0] code_i,
    output phoneme_addr_t     entry_o
);

    phoneme_addr_t entry_q;

    // Registered table read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_q <= '0;
        end else begin
            entry_q <= default_entry(code_i);
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/phoneme_sequencer.sv
// Phoneme playback scheduler: buffers phoneme codes in a FIFO, looks each
// one up in the address ROM and runs the flash player one phoneme at a time.
// Optional feature macro: PHONEME_GAP_EN inserts GAP_SYNCS sync pulses of
// silence after every phoneme.
//
// Code input handshake: a code is taken on a clock edge where code_valid and
// code_ready are both high and flush is low. code_ready is registered from
// the FIFO count, so a full FIFO refuses a push even when a pop happens in
// the same cycle; a refused push sets the sticky overflow flag.
module phoneme_sequencer
    import speech_pkg::*;
#(
    parameter int QUEUE_DEPTH = 8,
    parameter int GAP_SYNCS   = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CODE_W-1:0]            code_in,
    input  logic                         code_valid,
    output logic                         code_ready,
    input  logic                         flush,
    input  logic                         sync,
    input  logic                         player_done,
    output logic                         player_start,
    output logic                         play,
    output logic [ADDR_W-1:0]            start_addr,
    output logic [ADDR_W-1:0]            finish_addr,
    output logic                         busy,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count,
    output logic                         overflow,
    output logic                         bad_entry,
    output seq_state_t                   dbg_state
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_DEPTH);

    logic [CODE_W-1:0] mem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ready_q;
    logic              overflow_q;

    seq_state_t        state_q;
    logic [CODE_W-1:0] rom_code_q;
    phoneme_addr_t     rom_entry;
    logic [ADDR_W-1:0] start_addr_q, finish_addr_q;
    logic              start_q;
    logic              done_prev_q;
    logic              bad_q;

    logic push, pop;

    assign push = code_valid && ready_q && !flush;
    assign pop  = (state_q == ST_IDLE) && (count_q != '0) && !flush;

    // Next FIFO occupancy; push and pop together leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= code_in;
        end
    end

    // FIFO pointers, occupancy, registered ready and overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            ready_q <= (count_d != FULL_COUNT);
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                if (code_valid && !ready_q) overflow_q <= 1'b1;
            end
        end
    end

    phoneme_addr_rom u_rom (
        .clk     (clk),
        .reset   (reset),
        .code_i  (rom_code_q),
        .entry_o (rom_entry)
    );

`ifdef PHONEME_GAP_EN
    localparam int GAP_W = $clog2(GAP_SYNCS + 1);
    logic [GAP_W-1:0] gap_cnt_q;
`else
    // Without the gap feature, sync and GAP_SYNCS have no effect.
    logic        unused_sync;
    logic [31:0] unused_gap_syncs;
    assign unused_sync      = sync;
    assign unused_gap_syncs = GAP_SYNCS;
`endif

    // Playback FSM with registered player handshake and address outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rom_code_q    <= '0;
            start_addr_q  <= '0;
            finish_addr_q <= '0;
            start_q       <= 1'b0;
            done_prev_q   <= 1'b0;
            bad_q         <= 1'b0;
`ifdef PHONEME_GAP_EN
            gap_cnt_q     <= '0;
`endif
        end else begin
            // Tracked in every state so a done level left over from the
            // previous phoneme is never mistaken for a fresh completion.
            done_prev_q <= player_done;
            if (flush) begin
                state_q <= ST_IDLE;
                start_q <= 1'b0;
`ifdef PHONEME_GAP_EN
                gap_cnt_q <= '0;
`endif
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (pop) begin
                            rom_code_q <= mem_q[rd_ptr_q];
                            state_q    <= ST_LOOKUP;
                        end
                    end
                    ST_LOOKUP: begin
                        state_q <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        if (rom_entry.finish < rom_entry.start) begin
                            bad_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            start_addr_q  <= rom_entry.start;
                            finish_addr_q <= rom_entry.finish;
                            start_q       <= 1'b1;
                            state_q       <= ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        if (player_done && !done_prev_q) begin
                            start_q <= 1'b0;
`ifdef PHONEME_GAP_EN
                            gap_cnt_q <= '0;
                            state_q   <= ST_GAP;
`else
                            state_q <= ST_IDLE;
`endif
                        end
                    end
`ifdef PHONEME_GAP_EN
                    ST_GAP: begin
                        if (sync) begin
                            if (gap_cnt_q == GAP_W'(GAP_SYNCS - 1)) begin
                                gap_cnt_q <= '0;
                                state_q   <= ST_IDLE;
                            end else begin
                                gap_cnt_q <= gap_cnt_q + 1'b1;
                            end
                        end
                    end
`endif
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign code_ready   = ready_q;
    assign player_start = start_q;
    assign play         = start_q;
    assign start_addr   = start_addr_q;
    assign finish_addr  = finish_addr_q;
    assign busy         = (state_q != ST_IDLE) || (count_q != '0);
    assign queue_count  = count_q;
    assign overflow     = overflow_q;
    assign bad_entry    = bad_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_phoneme_sequencer.sv
// Bench for phoneme_sequencer: a player model answers the start handshake,
// a monitor checks every phoneme against a queue of expected codes and the
// address table, and one task per scenario drives and checks the rest.
module tb_phoneme_sequencer;
    import speech_pkg::*;

    logic        clk, reset, code_valid, flush, sync, player_done;
    logic [5:0]  code_in;
    logic        code_ready, player_start, play, busy, overflow, bad_entry;
    logic [23:0] start_addr, finish_addr;
    logic [3:0]  queue_count;
    seq_state_t  dbg_state;

    int n_pass  = 0;
    int n_total = 0;
    bit stall   = 0;
    bit manual  = 0;
    logic [5:0] exp_q[$];
`ifdef PHONEME_GAP_EN
    int gap_syncs = 0;
    bit gap_armed = 0;
`endif

    phoneme_sequencer #(.QUEUE_DEPTH(8), .GAP_SYNCS(64)) dut (
        .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
        .code_ready(code_ready), .flush(flush), .sync(sync),
        .player_done(player_done), .player_start(player_start), .play(play),
        .start_addr(start_addr), .finish_addr(finish_addr), .busy(busy),
        .queue_count(queue_count), .overflow(overflow), .bad_entry(bad_entry),
        .dbg_state(dbg_state)
    );

    // Clock and safety watchdog.
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Sync pulse every 4 clocks, changed away from the sampling point.
    initial begin
        int cyc = 0;
        sync = 0;
        forever begin
            @(posedge clk); #2;
            sync = (cyc % 4 == 0);
            cyc++;
        end
    end

    // Expected flash window for a code, straight from the phoneme table.
    function automatic logic [47:0] ref_entry(input logic [5:0] c);
        int s;
        if (c == 6'd2) return {24'h000800, 24'h0007FF};
        if (c == 6'd5) return {24'h001000, 24'h001FFF};
        s = int'(c) * 65536;
        return {24'(s), 24'(s + 4095)};
    endfunction

    // Player model: drops done when start rises, raises it after a random
    // delay unless stalled, then holds it until the next start.
    initial begin
        bit seen = 0;
        int dly = 0;
        player_done = 0;
        forever begin
            @(posedge clk); #1;
            if (!manual) begin
                if (player_start && !seen) begin
                    seen = 1;
                    player_done = 0;
                    dly = $urandom_range(1, 6);
                end else if (player_start && seen && !stall) begin
                    if (dly == 0) player_done = 1;
                    else dly--;
                end else if (!player_start) begin
                    seen = 0;
                end
            end
        end
    end

    // Monitor: order, addresses, stability and spacing of phonemes.
    initial begin
        bit prev_s = 0;
        int high_len = 0;
        int low_len = 100;
        logic [5:0]  c;
        logic [47:0] e;
        logic [23:0] lat_s, lat_f;
        lat_s = '0;
        lat_f = '0;
        forever begin
            @(posedge clk); #1;
`ifdef PHONEME_GAP_EN
            if (!prev_s && sync) gap_syncs++;
`endif
            if (player_start && !prev_s) begin
                n_total++;
                if (low_len < 3) $display("FAIL start_spacing: low for %0d clk, need >= 3", low_len);
                else n_pass++;
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_start: start_addr %06h with no code expected", start_addr);
                end else begin
                    c = exp_q.pop_front();
                    e = ref_entry(c);
                    if (start_addr !== e[47:24] || finish_addr !== e[23:0])
                        $display("FAIL phoneme_addr: code %0d got %06h..%06h expected %06h..%06h",
                                 c, start_addr, finish_addr, e[47:24], e[23:0]);
                    else n_pass++;
                end
`ifdef PHONEME_GAP_EN
                if (gap_armed) begin
                    n_total++;
                    if (gap_syncs !== 64) $display("FAIL gap_syncs: got %0d expected 64", gap_syncs);
                    else n_pass++;
                end
`endif
                lat_s = start_addr;
                lat_f = finish_addr;
                high_len = 1;
            end else if (player_start) begin
                high_len++;
                n_total++;
                if (start_addr !== lat_s || finish_addr !== lat_f)
                    $display("FAIL addr_stable: got %06h..%06h expected %06h..%06h",
                             start_addr, finish_addr, lat_s, lat_f);
                else n_pass++;
            end else if (prev_s) begin
                n_total++;
                if (high_len < 2) $display("FAIL early_done: start high %0d clk, need >= 2", high_len);
                else n_pass++;
                low_len = 1;
`ifdef PHONEME_GAP_EN
                gap_syncs = 0;
                gap_armed = 1;
`endif
            end else begin
                low_len++;
            end
            prev_s = player_start;
        end
    end

    task automatic push_one(input logic [5:0] c, input bit accept);
        code_in = c;
        code_valid = 1;
        if (accept && c != 6'd2) exp_q.push_back(c);
        @(posedge clk); #1;
        code_valid = 0;
    endtask

    task automatic wait_start();
        int i;
        for (i = 0; i < 50; i++) begin
            if (player_start) break;
            @(posedge clk); #1;
        end
        n_total++;
        if (!player_start) $display("FAIL wait_start: player_start got 0 expected 1 within 50 clk");
        else n_pass++;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 30000; i++) begin
            if (!busy && !player_start) break;
            @(posedge clk); #1;
        end
        n_total++;
        if (busy || player_start) $display("FAIL wait_idle: busy %0b start %0b expected 0 0", busy, player_start);
        else n_pass++;
        n_total++;
        if (exp_q.size() != 0) $display("FAIL drain: %0d phonemes not played, expected 0", exp_q.size());
        else n_pass++;
    endtask

    function automatic logic [5:0] rand_code();
        logic [5:0] c;
        c = 6'($urandom_range(0, 63));
        if (c == 6'd2) c = 6'd3;
        return c;
    endfunction

    task automatic test_reset();
        reset = 1; code_valid = 0; flush = 0; code_in = 0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({player_start, play, busy, overflow, bad_entry, code_ready} !== 6'b0)
            $display("FAIL reset_flags: got %06b expected 000000",
                     {player_start, play, busy, overflow, bad_entry, code_ready});
        else n_pass++;
        n_total++;
        if (queue_count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", queue_count);
        else n_pass++;
        n_total++;
        if (start_addr !== 24'h0 || finish_addr !== 24'h0)
            $display("FAIL reset_addr: got %06h..%06h expected 0..0", start_addr, finish_addr);
        else n_pass++;
        n_total++;
        if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
        else n_pass++;
        reset = 0;
        @(posedge clk); #1;
        n_total++;
        if (code_ready !== 1'b1) $display("FAIL ready_after_reset: got %0b expected 1", code_ready);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0 || queue_count !== 4'd0)
            $display("FAIL idle_after_reset: busy %0b count %0d expected 0 0", busy, queue_count);
        else n_pass++;
    endtask

    task automatic test_single_latency();
        manual = 1;
        push_one(6'd5, 1);
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #1;
            n_total++;
            if (player_start !== 1'b0) $display("FAIL latency_early: clk %0d got 1 expected 0", k + 1);
            else n_pass++;
        end
        @(posedge clk); #1;
        n_total++;
        if (player_start !== 1'b1 || play !== 1'b1)
            $display("FAIL latency_4clk: start %0b play %0b expected 1 1", player_start, play);
        else n_pass++;
        n_total++;
        if (start_addr !== 24'h001000 || finish_addr !== 24'h001FFF)
            $display("FAIL code5_addr: got %06h..%06h expected 001000..001fff", start_addr, finish_addr);
        else n_pass++;
        @(posedge clk); #1;
        player_done = 1;
        @(posedge clk); #1;
        n_total++;
        if (player_start !== 1'b0 || play !== 1'b0)
            $display("FAIL done_drop: start %0b play %0b expected 0 0", player_start, play);
        else n_pass++;
        wait_idle();
        manual = 0;
    endtask

    task automatic test_full();
        stall = 1;
        push_one(6'd1, 1);
        wait_start();
        for (int i = 0; i < 9; i++) begin
            if (i == 8) begin
                n_total++;
                if (code_ready !== 1'b0 || overflow !== 1'b0)
                    $display("FAIL full_ready: ready %0b ovf %0b expected 0 0", code_ready, overflow);
                else n_pass++;
            end
            push_one(rand_code(), i < 8);
        end
        n_total++;
        if (queue_count !== 4'd8) $display("FAIL full_count: got %0d expected 8", queue_count);
        else n_pass++;
        n_total++;
        if (code_ready !== 1'b0 || overflow !== 1'b1)
            $display("FAIL overflow: ready %0b ovf %0b expected 0 1", code_ready, overflow);
        else n_pass++;
        stall = 0;
        wait_idle();
    endtask

    task automatic test_back_to_back();
        push_one(6'd3, 1);
        push_one(6'd7, 1);
        push_one(6'd3, 1);
        wait_idle();
    endtask

    task automatic test_bad_entry();
        n_total++;
        if (bad_entry !== 1'b0) $display("FAIL bad_before: got %0b expected 0", bad_entry);
        else n_pass++;
        push_one(6'd2, 1);
        push_one(6'd5, 1);
        wait_idle();
        n_total++;
        if (bad_entry !== 1'b1) $display("FAIL bad_entry: got %0b expected 1", bad_entry);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                push_one(rand_code(), 1);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #0;
            end
            wait_idle();
        end
    endtask

    task automatic test_flush();
        stall = 1;
        push_one(6'd4, 1);
        wait_start();
        for (int i = 0; i < 4; i++) push_one(rand_code(), 1);
        n_total++;
        if (queue_count !== 4'd4) $display("FAIL flush_prefill: got %0d expected 4", queue_count);
        else n_pass++;
        flush = 1;
        code_valid = 1;
        code_in = 6'd9;
        @(posedge clk); #1;
        flush = 0;
        code_valid = 0;
        n_total++;
        if (player_start !== 1'b0 || queue_count !== 4'd0 || busy !== 1'b0)
            $display("FAIL flush: start %0b count %0d busy %0b expected 0 0 0",
                     player_start, queue_count, busy);
        else n_pass++;
        n_total++;
        if (overflow !== 1'b1 || bad_entry !== 1'b1 || code_ready !== 1'b1)
            $display("FAIL flush_sticky: ovf %0b bad %0b ready %0b expected 1 1 1",
                     overflow, bad_entry, code_ready);
        else n_pass++;
        #1;
        exp_q.delete();
`ifdef PHONEME_GAP_EN
        gap_armed = 0;
`endif
        stall = 0;
        repeat (3) @(posedge clk);
        #1;
        push_one(6'd5, 1);
        wait_idle();
    endtask

    task automatic test_reset_mid_play();
        stall = 1;
        push_one(6'd6, 1);
        wait_start();
        @(posedge clk); #3;
        reset = 1;
        #1;
        n_total++;
        if (player_start !== 1'b0 || play !== 1'b0)
            $display("FAIL async_reset: start %0b play %0b expected 0 0", player_start, play);
        else n_pass++;
        repeat (2) @(posedge clk);
        #2;
        reset = 0;
        exp_q.delete();
`ifdef PHONEME_GAP_EN
        gap_armed = 0;
`endif
        stall = 0;
        @(posedge clk); #1;
        n_total++;
        if (overflow !== 1'b0 || bad_entry !== 1'b0 || queue_count !== 4'd0)
            $display("FAIL reset_clears: ovf %0b bad %0b count %0d expected 0 0 0",
                     overflow, bad_entry, queue_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_latency();
        test_full();
        test_back_to_back();
        test_bad_entry();
        test_random();
        test_flush();
        test_reset_mid_play();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
